// File: rtl/irq_pending_latch.sv
// irq_pending_latch: synchronizes eight async interrupt lines, latches rising
// edges as pending bits and runs a REQ/ACK handshake with a downstream consumer.
module irq_pending_latch #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irq_in,
    input  logic [7:0] mask,
    input  logic       ack,
    input  logic [2:0] ack_id,
    output logic [7:0] pend_out,
    output logic       irq_req,
    output logic [7:0] ovr,
    output logic       ack_err
);

    localparam int unsigned N_SRC = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t state_q, state_nxt;

    logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q;
    logic [N_SRC-1:0] dly_q;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pending_q, pending_nxt;
    logic [N_SRC-1:0] ovr_nxt;
    logic [N_SRC-1:0] ack_sel;
    logic [N_SRC-1:0] clr;
    logic             ack_in_req;
    logic             ack_hit;
    logic             ack_err_nxt;

    // First synchronizer stage samples the raw lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q[0] <= '0;
        else        sync_q[0] <= irq_in;
    end

    for (genvar s = 1; s < SYNC_STAGES; s++) begin : g_sync
        // Remaining synchronizer stages
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sync_q[s] <= '0;
            else        sync_q[s] <= sync_q[s-1];
        end
    end

    // Delayed copy of the last sync stage; resetting to 0 makes a line that is
    // already high at reset release look like a fresh rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dly_q <= '0;
        else        dly_q <= sync_q[SYNC_STAGES-1];
    end

    assign rise     = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign pend_out = pending_q & mask;

    // Pending/overrun/error update; a new edge always beats a same-cycle clear
    always_comb begin
        ack_sel     = N_SRC'(1) << ack_id;
        ack_in_req  = ack && (state_q == S_REQ);
        ack_hit     = ack_in_req && pending_q[ack_id];
        clr         = ack_hit ? ack_sel : '0;
        pending_nxt = (pending_q & ~clr) | rise;
        // A colliding edge keeps the overrun history since the slot is re-armed
        ovr_nxt     = (ovr & ~(clr & ~rise)) | (rise & pending_q & ~clr);
        ack_err_nxt = ack_err | (ack && !ack_hit);
    end

    // Handshake next-state: REQ until ack or nothing visible, HOLD for one cycle
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:  if (pend_out != '0) state_nxt = S_REQ;
            S_REQ: begin
                if (ack)                  state_nxt = S_HOLD;
                else if (pend_out == '0)  state_nxt = S_IDLE;
            end
            S_HOLD:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            irq_req   <= 1'b0;
            pending_q <= '0;
            ovr       <= '0;
            ack_err   <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            irq_req   <= (state_nxt == S_REQ);
            pending_q <= pending_nxt;
            ovr       <= ovr_nxt;
            ack_err   <= ack_err_nxt;
        end
    end

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed bench for irq_pending_latch (SYNC_STAGES = 2).
module tb_irq_pending_latch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq_in;
    logic [7:0] mask;
    logic       ack;
    logic [2:0] ack_id;
    logic [7:0] pend_out;
    logic       irq_req;
    logic [7:0] ovr;
    logic       ack_err;

    int checks = 0;
    int errors = 0;

    irq_pending_latch #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq_in   (irq_in),
        .mask     (mask),
        .ack      (ack),
        .ack_id   (ack_id),
        .pend_out (pend_out),
        .irq_req  (irq_req),
        .ovr      (ovr),
        .ack_err  (ack_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Single-cycle ack pulse
    task automatic do_ack(input logic [2:0] id);
        ack    = 1'b1;
        ack_id = id;
        tick();
        ack    = 1'b0;
    endtask

    // One-cycle pulse on irq_in; returns right after the sampling edge
    task automatic pulse(input logic [7:0] v);
        irq_in = v;
        tick();
        irq_in = 8'h00;
    endtask

    initial begin
        rst_n  = 1'b0;
        irq_in = 8'h00;
        mask   = 8'hFF;
        ack    = 1'b0;
        ack_id = 3'd0;
        #3;
        check("rst_pend", 32'(pend_out), 32'h00);
        check("rst_req",  32'(irq_req),  32'h0);
        check("rst_ovr",  32'(ovr),      32'h00);
        check("rst_err",  32'(ack_err),  32'h0);
        ticks(2);
        rst_n = 1'b1;
        ticks(2);

        // Single source pulse and ack
        pulse(8'h04);
        tick();
        check("s1_pend_early", 32'(pend_out), 32'h00);
        tick();
        check("s1_pend", 32'(pend_out), 32'h04);
        check("s1_req_early", 32'(irq_req), 32'h0);
        tick();
        check("s1_req", 32'(irq_req), 32'h1);
        do_ack(3'd2);
        check("s1_pend_clr", 32'(pend_out), 32'h00);
        check("s1_req_hold", 32'(irq_req), 32'h0);
        tick();
        check("s1_req_idle", 32'(irq_req), 32'h0);
        tick();
        check("s1_req_stay", 32'(irq_req), 32'h0);
        check("s1_err", 32'(ack_err), 32'h0);

        // Two sources in the same cycle, drained one by one
        pulse(8'h81);
        ticks(2);
        check("m_pend", 32'(pend_out), 32'h81);
        tick();
        check("m_req", 32'(irq_req), 32'h1);
        do_ack(3'd0);
        check("m_pend0", 32'(pend_out), 32'h80);
        check("m_req_hold", 32'(irq_req), 32'h0);
        tick();
        check("m_req_idle", 32'(irq_req), 32'h0);
        tick();
        check("m_req_again", 32'(irq_req), 32'h1);
        do_ack(3'd7);
        check("m_pend_empty", 32'(pend_out), 32'h00);
        ticks(2);
        check("m_req_done", 32'(irq_req), 32'h0);

        // Masked edge is retained and released by the mask
        mask = 8'h00;
        pulse(8'h08);
        ticks(2);
        check("k_pend_masked", 32'(pend_out), 32'h00);
        tick();
        check("k_req_masked", 32'(irq_req), 32'h0);
        mask = 8'h08;
        #1;
        check("k_pend_unmask", 32'(pend_out), 32'h08);
        tick();
        check("k_req_unmask", 32'(irq_req), 32'h1);
        mask = 8'h00;
        tick();
        check("k_req_drop", 32'(irq_req), 32'h0);
        check("k_pend_drop", 32'(pend_out), 32'h00);
        mask = 8'hFF;
        tick();
        check("k_req_remask", 32'(irq_req), 32'h1);
        do_ack(3'd3);
        ticks(2);
        check("k_pend_done", 32'(pend_out), 32'h00);

        // Overrun, collision and overrun clear on bit 5
        pulse(8'h20);
        ticks(2);
        check("o_pend", 32'(pend_out), 32'h20);
        pulse(8'h20);
        tick();
        check("o_ovr_pre", 32'(ovr), 32'h00);
        tick();
        check("o_ovr", 32'(ovr), 32'h20);
        check("o_req", 32'(irq_req), 32'h1);
        pulse(8'h20);
        tick();
        do_ack(3'd5);
        check("o_coll_pend", 32'(pend_out), 32'h20);
        check("o_coll_ovr", 32'(ovr), 32'h20);
        tick();
        tick();
        check("o_req_again", 32'(irq_req), 32'h1);
        do_ack(3'd5);
        check("o_ovr_clr", 32'(ovr), 32'h00);
        check("o_pend_clr", 32'(pend_out), 32'h00);
        check("o_err", 32'(ack_err), 32'h0);
        ticks(2);

        // Ack errors: in IDLE, then in REQ for a non-pending id
        do_ack(3'd0);
        check("e_idle_err", 32'(ack_err), 32'h1);
        check("e_idle_req", 32'(irq_req), 32'h0);
        tick();
        check("e_idle_stay", 32'(irq_req), 32'h0);
        pulse(8'h02);
        ticks(3);
        check("e_req", 32'(irq_req), 32'h1);
        do_ack(3'd6);
        check("e_bad_hold", 32'(irq_req), 32'h0);
        check("e_bad_pend", 32'(pend_out), 32'h02);
        tick();
        check("e_bad_idle", 32'(irq_req), 32'h0);
        tick();
        check("e_bad_rereq", 32'(irq_req), 32'h1);
        do_ack(3'd1);
        ticks(2);

        // Async reset while requesting, then a line held high through release
        pulse(8'hF0);
        ticks(3);
        check("r_pend", 32'(pend_out), 32'hF0);
        check("r_req", 32'(irq_req), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("r_async_pend", 32'(pend_out), 32'h00);
        check("r_async_req",  32'(irq_req),  32'h0);
        check("r_async_ovr",  32'(ovr),      32'h00);
        check("r_async_err",  32'(ack_err),  32'h0);
        irq_in = 8'h01;
        tick();
        rst_n = 1'b1;
        ticks(2);
        check("r_rel_early", 32'(pend_out), 32'h00);
        tick();
        check("r_rel_pend", 32'(pend_out), 32'h01);
        ticks(3);
        check("r_held_pend", 32'(pend_out), 32'h01);
        check("r_held_ovr", 32'(ovr), 32'h00);
        irq_in = 8'h00;
        ticks(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
